// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter slice.
package mips_bus_pkg;

   localparam int AVL_ADDR_W = 32;
   localparam int AVL_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_G0   = 2'd1,
      ARB_G1   = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   function automatic logic [1:0] grant_of(arb_state_t st);
      case (st)
         ARB_G0:  return GRANT_M0;
         ARB_G1:  return GRANT_M1;
         default: return GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mips_avalon_bus_arbiter_if.sv
// Avalon-MM command/response bundle; master drives the command, slave answers.
interface mips_avalon_bus_arbiter_if
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W = AVL_ADDR_W,
   parameter int DATA_W = AVL_DATA_W
) ();

   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );

endinterface

// File: rtl/mips_bus_watchdog.sv
// Saturating stall counter with a sticky error flag; TIMEOUT = 0 disables it.
module mips_bus_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   output logic err
);
   localparam bit          ENABLED = (TIMEOUT > 0);
   localparam int          CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (ENABLED && stall) begin
         if (cnt != LIMIT) cnt <= cnt + 1'b1;
         if (cnt == LIMIT - 1'b1) err <= 1'b1;
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/mips_avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter: whole-transfer grants, round-robin on contention,
// and the owner's command passed combinationally to the single slave.
module mips_avalon_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W  = AVL_ADDR_W,
   parameter int DATA_W  = AVL_DATA_W,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   mips_avalon_bus_arbiter_if.slave  m0,
   mips_avalon_bus_arbiter_if.slave  m1,
   mips_avalon_bus_arbiter_if.master s,
   output logic [1:0]                grant,
   output logic                      err
);
   localparam int BE_W = DATA_W / 8;

   arb_state_t        state, state_next;
   logic              last_grant;   // 1 when m1 was granted most recently
   logic              req0, req1, owner_req;
   logic [ADDR_W-1:0] cmd_address;
   logic              cmd_read, cmd_write;
   logic [DATA_W-1:0] cmd_writedata;
   logic [BE_W-1:0]   cmd_byteenable;

   assign req0 = m0.read | m0.write;
   assign req1 = m1.read | m1.write;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_next;
         if (state_next == ARB_G0)      last_grant <= 1'b0;
         else if (state_next == ARB_G1) last_grant <= 1'b1;
      end
   end

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      owner_req  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (req0 && req1) state_next = last_grant ? ARB_G0 : ARB_G1;
            else if (req0)    state_next = ARB_G0;
            else if (req1)    state_next = ARB_G1;
         end
         ARB_G0: begin
            owner_req = req0;
            // Ownership ends on completion or when the owner withdraws its request.
            if (!req0)               state_next = ARB_IDLE;
            else if (!s.waitrequest) state_next = req1 ? ARB_G1 : ARB_IDLE;
         end
         ARB_G1: begin
            owner_req = req1;
            if (!req1)               state_next = ARB_IDLE;
            else if (!s.waitrequest) state_next = req0 ? ARB_G0 : ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      cmd_address    = '0;
      cmd_read       = 1'b0;
      cmd_write      = 1'b0;
      cmd_writedata  = '0;
      cmd_byteenable = '0;
      m0.waitrequest = 1'b1;
      m1.waitrequest = 1'b1;
      case (state)
         ARB_G0: begin
            cmd_address    = m0.address;
            cmd_read       = m0.read;
            cmd_write      = m0.write;
            cmd_writedata  = m0.writedata;
            cmd_byteenable = m0.byteenable;
            m0.waitrequest = s.waitrequest;
         end
         ARB_G1: begin
            cmd_address    = m1.address;
            cmd_read       = m1.read;
            cmd_write      = m1.write;
            cmd_writedata  = m1.writedata;
            cmd_byteenable = m1.byteenable;
            m1.waitrequest = s.waitrequest;
         end
         default: ;
      endcase
   end

   assign s.address    = cmd_address;
   assign s.read       = cmd_read;
   assign s.write      = cmd_write;
   assign s.writedata  = cmd_writedata;
   assign s.byteenable = cmd_byteenable;

   // Both masters see read data continuously and qualify it with their own waitrequest.
   assign m0.readdata = s.readdata;
   assign m1.readdata = s.readdata;

   assign grant = grant_of(state);

   mips_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .stall (owner_req & s.waitrequest),
      .err   (err)
   );

endmodule

// File: tb/tb_mips_avalon_bus_arbiter.sv
// Directed and randomized bench for mips_avalon_bus_arbiter against a transfer-level model.
module tb_mips_avalon_bus_arbiter;
   import mips_bus_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] grant;
   logic       err;

   mips_avalon_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
   mips_avalon_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
   mips_avalon_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

   mips_avalon_bus_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .m0    (m0_bus),
      .m1    (m1_bus),
      .s     (s_bus),
      .grant (grant),
      .err   (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Transfer-level model: who owns the slave (0 none, 1 m0, 2 m1), tie preference, stall age.
   int owner     = 0;
   bit prefer_m0 = 1'b1;
   int wd        = 0;
   bit err_m     = 1'b0;
   bit done0, done1;

   bit          act   [2];
   bit          is_wr [2];
   logic [31:0] adr   [2];
   logic [31:0] wdat  [2];
   logic [3:0]  be    [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_update();
      bit r0, r1, rq, ro;
      int nxt;
      r0    = m0_bus.read | m0_bus.write;
      r1    = m1_bus.read | m1_bus.write;
      done0 = 1'b0;
      done1 = 1'b0;
      if (!reset) begin
         owner = 0; prefer_m0 = 1'b1; wd = 0; err_m = 1'b0;
         return;
      end
      nxt = owner;
      if (owner == 0) begin
         if (r0 && r1) nxt = prefer_m0 ? 1 : 2;
         else if (r0)  nxt = 1;
         else if (r1)  nxt = 2;
         wd = 0;
      end else begin
         rq = (owner == 1) ? r0 : r1;
         ro = (owner == 1) ? r1 : r0;
         if (!rq) begin
            nxt = 0; wd = 0;
         end else if (!s_bus.waitrequest) begin
            if (owner == 1) done0 = 1'b1; else done1 = 1'b1;
            nxt = ro ? 3 - owner : 0;
            wd  = 0;
         end else begin
            if (wd < TO) wd++;
            if (wd >= TO) err_m = 1'b1;
         end
      end
      if (nxt != 0) prefer_m0 = (nxt == 2);
      owner = nxt;
   endtask

   task automatic check_all(input string tag);
      logic [1:0]    eg;
      logic          erd, ewr, ew0, ew1;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [BW-1:0] eb;
      eg = GRANT_NONE; erd = 1'b0; ewr = 1'b0; ea = '0; ed = '0; eb = '0; ew0 = 1'b1; ew1 = 1'b1;
      if (owner == 1) begin
         eg = 2'b01; erd = m0_bus.read; ewr = m0_bus.write; ea = m0_bus.address;
         ed = m0_bus.writedata; eb = m0_bus.byteenable; ew0 = s_bus.waitrequest;
      end else if (owner == 2) begin
         eg = 2'b10; erd = m1_bus.read; ewr = m1_bus.write; ea = m1_bus.address;
         ed = m1_bus.writedata; eb = m1_bus.byteenable; ew1 = s_bus.waitrequest;
      end
      chk({tag, "/grant"},   grant, eg);
      chk({tag, "/s_read"},  s_bus.read, erd);
      chk({tag, "/s_write"}, s_bus.write, ewr);
      chk({tag, "/s_addr"},  s_bus.address, ea);
      chk({tag, "/s_wdata"}, s_bus.writedata, ed);
      chk({tag, "/s_be"},    s_bus.byteenable, eb);
      chk({tag, "/m0_wait"}, m0_bus.waitrequest, ew0);
      chk({tag, "/m1_wait"}, m1_bus.waitrequest, ew1);
      chk({tag, "/m0_rd"},   m0_bus.readdata, s_bus.readdata);
      chk({tag, "/m1_rd"},   m1_bus.readdata, s_bus.readdata);
      chk({tag, "/err"},     err, err_m);
   endtask

   task automatic settle(input string tag);
      #4;
      check_all(tag);
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_m0(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = d; m0_bus.byteenable = b;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = d; m1_bus.byteenable = b;
   endtask

   task automatic drive_random();
      for (int i = 0; i < 2; i++) begin
         if ((i == 0 && done0) || (i == 1 && done1)) act[i] = 1'b0;
         if (act[i] && $urandom_range(31) == 0) begin
            act[i] = 1'b0;
         end else if (!act[i] && $urandom_range(1) == 0) begin
            act[i]   = 1'b1;
            is_wr[i] = 1'($urandom_range(1));
            adr[i]   = $urandom;
            wdat[i]  = $urandom;
            be[i]    = 4'($urandom_range(15));
         end
      end
      set_m0(act[0] & ~is_wr[0], act[0] & is_wr[0], adr[0], wdat[0], be[0]);
      set_m1(act[1] & ~is_wr[1], act[1] & is_wr[1], adr[1], wdat[1], be[1]);
      s_bus.waitrequest = ($urandom_range(1) == 0);
      s_bus.readdata    = $urandom;
      reset             = ($urandom_range(63) != 0);
   endtask

   initial begin
      int n0, n1;
      set_m0(0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0);
      s_bus.waitrequest = 1'b0;
      s_bus.readdata    = '0;

      // Reset state
      advance();
      advance();
      settle("reset");
      chk("reset_grant", grant, 2'b00);
      chk("reset_m0_wait", m0_bus.waitrequest, 1'b1);
      chk("reset_m1_wait", m1_bus.waitrequest, 1'b1);
      chk("reset_err", err, 1'b0);

      // Lone m0 read with zero-wait slave
      reset = 1'b1;
      set_m0(1, 0, 32'h0000_1000, 32'h0, 4'hf);
      s_bus.readdata = 32'hDEAD_BEEF;
      settle("t1_idle");
      chk("t1_wait_first", m0_bus.waitrequest, 1'b1);
      advance();
      settle("t1_g0");
      chk("t1_grant", grant, 2'b01);
      chk("t1_wait_second", m0_bus.waitrequest, 1'b0);
      chk("t1_rdata", m0_bus.readdata, 32'hDEAD_BEEF);
      chk("t1_s_addr", s_bus.address, 32'h0000_1000);
      advance();
      set_m0(0, 0, 0, 0, 0);
      settle("t1_done");
      chk("t1_back_idle", grant, 2'b00);
      chk("t1_read_one_cycle", s_bus.read, 1'b0);

      // Both write right after reset: m0 first, then m1 without an idle cycle
      reset = 1'b0;
      advance();
      reset = 1'b1;
      set_m0(0, 1, 32'h0000_2000, 32'h1111_1111, 4'h3);
      set_m1(0, 1, 32'h0000_3000, 32'h2222_2222, 4'hc);
      settle("t2_idle");
      advance();
      settle("t2_g0");
      chk("t2_first_m0", grant, 2'b01);
      chk("t2_m1_stalled", m1_bus.waitrequest, 1'b1);
      advance();
      set_m0(0, 0, 0, 0, 0);
      settle("t2_g1");
      chk("t2_handover", grant, 2'b10);
      chk("t2_m1_wdata", s_bus.writedata, 32'h2222_2222);
      chk("t2_m1_be", s_bus.byteenable, 4'hc);
      chk("t2_m0_stalled", m0_bus.waitrequest, 1'b1);
      advance();
      set_m1(0, 0, 0, 0, 0);
      settle("t2_done");

      // Continuous contention: grants alternate with no idle cycles
      set_m0(1, 0, 32'h0000_4000, 32'h0, 4'hf);
      set_m1(1, 0, 32'h0000_5000, 32'h0, 4'hf);
      settle("t3_idle");
      n0 = 0; n1 = 0;
      for (int i = 0; i < 8; i++) begin
         advance();
         s_bus.readdata = $urandom;
         settle("t3_alt");
         chk("t3_alternate", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (!m0_bus.waitrequest) n0++;
         if (!m1_bus.waitrequest) n1++;
      end
      chk("t3_m0_count", 64'(n0), 64'd4);
      chk("t3_m1_count", 64'(n1), 64'd4);
      advance();
      set_m0(0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0);
      settle("t3_abort_tail");
      advance();
      settle("t3_idle_end");

      // Watchdog: 3 stall cycles stay below TIMEOUT, 5 trip the sticky flag
      for (int rep = 0; rep < 2; rep++) begin
         set_m1(1, 0, 32'h0000_6000, 32'h0, 4'hf);
         s_bus.waitrequest = 1'b1;
         settle("t4_idle");
         advance();
         for (int k = 0; k < (rep == 0 ? 3 : 5); k++) begin
            settle("t4_stall");
            chk("t4_m1_stalled", m1_bus.waitrequest, 1'b1);
            advance();
         end
         s_bus.waitrequest = 1'b0;
         settle("t4_complete");
         chk("t4_m1_done", m1_bus.waitrequest, 1'b0);
         advance();
         set_m1(0, 0, 0, 0, 0);
         settle("t4_after");
         chk("t4_err", err, rep == 0 ? 1'b0 : 1'b1);
      end
      advance();
      settle("t4_sticky");
      chk("t4_err_sticky", err, 1'b1);

      // Reset in G1 while stalled, then a tie goes to m0
      set_m1(1, 0, 32'h0000_7000, 32'h0, 4'hf);
      s_bus.waitrequest = 1'b1;
      settle("t5_idle");
      advance();
      settle("t5_g1");
      chk("t5_in_g1", grant, 2'b10);
      reset = 1'b0;
      settle("t5_rst_asserted");
      advance();
      reset = 1'b1;
      set_m0(1, 0, 32'h0000_8000, 32'h0, 4'hf);
      s_bus.waitrequest = 1'b0;
      settle("t5_after_rst");
      chk("t5_grant", grant, 2'b00);
      chk("t5_s_read", s_bus.read, 1'b0);
      chk("t5_err", err, 1'b0);
      chk("t5_m0_wait", m0_bus.waitrequest, 1'b1);
      chk("t5_m1_wait", m1_bus.waitrequest, 1'b1);
      advance();
      settle("t5_tie");
      chk("t5_m0_wins", grant, 2'b01);
      advance();
      set_m0(0, 0, 0, 0, 0);
      settle("t5_m1");
      advance();
      set_m1(0, 0, 0, 0, 0);
      settle("t5_done");

      // m1 aborts mid-stall; pending m0 is granted after one idle cycle
      set_m1(1, 0, 32'h0000_9000, 32'h0, 4'hf);
      s_bus.waitrequest = 1'b1;
      settle("t6_idle");
      advance();
      settle("t6_g1");
      advance();
      set_m1(0, 0, 32'h0000_9000, 32'h0, 4'hf);
      set_m0(1, 0, 32'h0000_a000, 32'h0, 4'hf);
      settle("t6_abort");
      chk("t6_s_read_drops", s_bus.read, 1'b0);
      chk("t6_still_g1", grant, 2'b10);
      advance();
      settle("t6_idle_after");
      chk("t6_idle", grant, 2'b00);
      advance();
      s_bus.waitrequest = 1'b0;
      settle("t6_g0");
      chk("t6_m0_granted", grant, 2'b01);
      advance();
      set_m0(0, 0, 0, 0, 0);
      settle("t6_done");
      advance();

      // Randomized traffic with aborts, stalls and occasional reset
      for (int c = 0; c < 600; c++) begin
         drive_random();
         settle("rand");
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_avalon_bus_arbiter.md
Name: mips_avalon_bus_arbiter

Overview:
- Shares the single Avalon-MM memory slave between two masters: master 0 is the CPU bus port, master 1 is a secondary requester (loader/DMA/debug).
- Grants one whole transfer at a time, with round-robin on contention. It passes the granted master's command through to the slave and stalls the other master with waitrequest.
- Includes a stall watchdog that flags a hung slave.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable is DATA_W/8 bits
- TIMEOUT, 1024, cycles a granted transfer may stall before err is set; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_waitrequest  out  1  stall to master 0
- m0_readdata  out  DATA_W  read data to master 0
- m1_*  same set as m0_*, for master 1
- s_address  out  ADDR_W  slave address
- s_read  out  1  slave read
- s_write  out  1  slave write
- s_writedata  out  DATA_W  slave write data
- s_byteenable  out  DATA_W/8  slave byte enables
- s_waitrequest  in  1  slave stall
- s_readdata  in  DATA_W  slave read data, zero-latency
- grant  out  2  one-hot current owner; bit0 = m0, bit1 = m1
- err  out  1  sticky watchdog flag

Behaviour:
- Request definition: reqN = mN_read | mN_write. Read and write both high from one master is illegal; pass both through unchanged.
- Completion: a transfer completes in the cycle where the granted master's req is 1 and s_waitrequest is 0. s_readdata is valid in that same cycle.
- States:
  - IDLE: grant = 00.
  - G0: master 0 owns the slave.
  - G1: master 1 owns the slave.
  - State is registered; grant is decoded from state.
- From IDLE:
  - only req0 -> G0; only req1 -> G1; neither -> stay.
  - both -> grant the master opposite last_grant (1-bit register, updated on every grant).
- From GN on completion:
  - other master requesting -> G(other); otherwise -> IDLE.
  - A lone master therefore sees one IDLE cycle between back-to-back transfers.
- From GN when reqN drops without completion (protocol abort) -> IDLE. The slave command is removed in that same cycle, because it is combinational from mN_*.
- Grant latency: a request first seen in IDLE is granted at the next edge. The requester sees waitrequest = 1 in the first cycle; the earliest completion is in the 2nd cycle.
- Outputs in GN:
  - s_address, s_read, s_write, s_writedata, s_byteenable = mN_* combinationally.
  - mN_waitrequest = s_waitrequest.
- Outputs for non-granted masters and in IDLE:
  - non-granted mX_waitrequest = 1.
  - In IDLE, s_read = s_write = 0 and s_address, s_writedata, s_byteenable = 0.
- m0_readdata and m1_readdata both carry s_readdata at all times; masters qualify it with their own waitrequest.
- Watchdog:
  - Counter increments each cycle in G0/G1 while s_waitrequest = 1; clears on completion, abort, or IDLE.
  - When the count reaches TIMEOUT, err is set (sticky); the transfer is neither aborted nor forced.
  - The counter saturates at TIMEOUT.
- Reset (reset = 0 at an edge), including mid-transfer: state -> IDLE, last_grant -> 1 (m0 wins the first tie), counter -> 0, err -> 0.
  - Reset values: grant = 00, s_* = 0, m0_waitrequest = m1_waitrequest = 1.
- Simultaneous events:
  - Completion by GN with the other master requesting hands over at the next edge, with no idle cycle.
  - A new request from the same master in that cycle is not considered.

Decomposition:
- Shared package mips_bus_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_G0, ARB_G1}
  - grant encoding constants GRANT_NONE, GRANT_M0, GRANT_M1
  - Avalon width defaults
- One natural sub-module: mips_bus_watchdog, containing the counter, compare and sticky err, parameterised by TIMEOUT.
- The arbiter FSM and muxing stay in the top module.

Test Plan:
- Lone m0 read at 0x0000_1000, slave waitrequest = 0, readdata 0xDEADBEEF -> grant 01 after 1 cycle; m0_waitrequest 1,0; m0 captures 0xDEADBEEF; s_read high for exactly 1 cycle; state returns to IDLE.
- m0 and m1 both write from IDLE right after reset -> m0 served first. At m0's completion, grant switches to 10 on the next edge; m1's writedata and byteenable appear on s_*; m0_waitrequest stays 1 throughout m1's grant.
- Both masters request continuously for 8 transfers -> grants alternate 01,10,01,… with no IDLE cycles; each master completes 4 transfers.
- Slave holds waitrequest = 1 for 3 cycles on an m1 read -> m1 stalled for 3 cycles, then completes; with TIMEOUT = 4, err stays 0. Repeat with 5 stall cycles -> err = 1 and remains 1 after the transfer ends.
- Reset = 0 asserted while in G1 with the slave stalling -> next cycle grant = 00, s_read = 0, err = 0, both waitrequests = 1. After release, a simultaneous request from both masters is granted to m0.
- m1 drops read mid-stall (abort) -> s_read falls in the same cycle and the state returns to IDLE; a pending m0 is granted on the following edge.
